// File: rtl/sctag_rdmard_seq_pkg.sv
// rtl/sctag_rdmard_seq_pkg.sv - shared constants and types for the RDMA read return sequencer
//
// Purpose: ctag geometry, line geometry, error-flag latency and FSM encoding
// shared by the sequencer and its test environment.
package sctag_rdmard_seq_pkg;

  localparam int CTAG_W         = 15;
  localparam int IO_READ_BIT    = 12;
  localparam int RDMARD_NWORDS  = 16;
  localparam int RDMARD_ERR_LAT = 4;
  localparam int RDMARD_WORD_W  = $clog2(RDMARD_NWORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HDR  = 2'b01,
    ST_DATA = 2'b10
  } rdmard_state_t;

  // Every ctag handed to the datapath is marked as an IO read.
  function automatic logic [CTAG_W-1:0] io_read_ctag(input logic [CTAG_W-1:0] ctag);
    return ctag | (CTAG_W'(1) << IO_READ_BIT);
  endfunction

endpackage

// File: rtl/dff_s.sv
// rtl/dff_s.sv - scannable D flop bank
//
// Purpose: plain positive-edge register with a scan mux in front.
// Ports:
//   din  - functional data
//   clk  - clock
//   q    - registered output
//   se   - scan enable (selects si)
//   si   - scan data
module dff_s #(
  parameter int SIZE = 1
) (
  input  logic [SIZE-1:0] din,
  input  logic            clk,
  output logic [SIZE-1:0] q,
  input  logic            se,
  input  logic [SIZE-1:0] si
);

  always_ff @(posedge clk) begin
    q <= se ? si : din;
  end

endmodule

// File: rtl/sctag_rdmard_seq_fifo.sv
// rtl/sctag_rdmard_seq_fifo.sv - request FIFO for the RDMA read sequencer
//
// Purpose: DEPTH x WIDTH synchronous FIFO, count-based full/empty, built
// from dff_s banks. Reset is folded into the flop inputs.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push       - write push_data (ignored when full)
//   push_data  - entry to enqueue
//   pop        - discard head (ignored when empty)
//   head       - oldest entry
//   full       - DEPTH entries held
//   empty      - no entries held
module rdmard_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wptr, wptr_d, rptr, rptr_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] mem   [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  always_comb begin
    wptr_d = wptr;
    rptr_d = rptr;
    cnt_d  = cnt;
    if (rst) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr + PTR_W'(1);
      if (do_pop)  rptr_d = rptr + PTR_W'(1);
      cnt_d = cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once counted.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = (do_push && (wptr == PTR_W'(i))) ? push_data : mem[i];
    end
  end

  dff_s #(.SIZE(PTR_W)) u_wptr (.din(wptr_d), .clk(clk), .q(wptr), .se(1'b0), .si('0));
  dff_s #(.SIZE(PTR_W)) u_rptr (.din(rptr_d), .clk(clk), .q(rptr), .se(1'b0), .si('0));
  dff_s #(.SIZE(CNT_W)) u_cnt  (.din(cnt_d),  .clk(clk), .q(cnt),  .se(1'b0), .si('0));

  for (genvar g = 0; g < DEPTH; g++) begin : g_mem
    dff_s #(.SIZE(WIDTH)) u_ent (.din(mem_d[g]), .clk(clk), .q(mem[g]), .se(1'b0), .si('0));
  end

endmodule

// File: rtl/sctag_rdmard_seq.sv
// rtl/sctag_rdmard_seq.sv - RDMA read return sequencer (L2 data to JBI via scbuf)
//
// Purpose: queues RDMA read ctags, drives one header cycle then NWORDS
// word-select cycles on the scbuf c7 pins, and folds the per-word ECC
// flags returning ERR_LAT cycles later into one completion per request.
// Ports:
//   rclk, rst                  - clock, synchronous active-high reset
//   req_vld/req_ctag/req_rdy   - request enqueue handshake
//   jbi_hold                   - gates the start of a new header only
//   sctag_scbuf_*_c7           - header/word controls to the datapath
//   scbuf_sctag_rdma_*err_c10  - per-word error flags, ERR_LAT after issue
//   rdmard_done*               - completion pulse with ctag and UE/CE summary
//   busy                       - queue, FSM or error window active
module sctag_rdmard_seq
  import sctag_rdmard_seq_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int NWORDS  = RDMARD_NWORDS,
  parameter int ERR_LAT = RDMARD_ERR_LAT
) (
  input  logic                     rclk,
  input  logic                     rst,
  input  logic                     req_vld,
  input  logic [CTAG_W-1:0]        req_ctag,
  output logic                     req_rdy,
  input  logic                     jbi_hold,
  output logic                     sctag_scbuf_ctag_en_c7,
  output logic [CTAG_W-1:0]        sctag_scbuf_ctag_c7,
  output logic                     sctag_scbuf_req_en_c7,
  output logic [RDMARD_WORD_W-1:0] sctag_scbuf_word_c7,
  output logic                     sctag_scbuf_word_vld_c7,
  input  logic                     scbuf_sctag_rdma_uerr_c10,
  input  logic                     scbuf_sctag_rdma_cerr_c10,
  output logic                     rdmard_done,
  output logic [CTAG_W-1:0]        rdmard_done_ctag,
  output logic                     rdmard_done_ue,
  output logic                     rdmard_done_ce,
  output logic                     busy
);

  rdmard_state_t            state, state_d;
  logic [RDMARD_WORD_W-1:0] word_cnt, word_cnt_d;
  logic [CTAG_W-1:0]        fifo_head, cur_ctag, ctag_q;
  logic                     fifo_full, fifo_empty, fifo_pop;
  logic                     in_hdr, in_data, last_word, can_start;

  logic [ERR_LAT-1:0]       dl_vld, dl_last;
  logic [CTAG_W-1:0]        dl_ctag [ERR_LAT];
  logic                     out_vld, out_done, acc_ue, acc_ce, ue_any;

  assign req_rdy = ~fifo_full;

  rdmard_req_fifo #(.DEPTH(QDEPTH), .WIDTH(CTAG_W)) u_fifo (
    .clk       (rclk),
    .rst       (rst),
    .push      (req_vld),
    .push_data (req_ctag),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_hdr    = (state == ST_HDR);
  assign in_data   = (state == ST_DATA);
  assign last_word = in_data && (word_cnt == RDMARD_WORD_W'(NWORDS - 1));
  assign can_start = ~fifo_empty & ~jbi_hold;

  always_comb begin
    state_d    = state;
    word_cnt_d = word_cnt;
    fifo_pop   = 1'b0;
    unique case (state)
      ST_IDLE: if (can_start) state_d = ST_HDR;
      ST_HDR: begin
        fifo_pop   = 1'b1;
        word_cnt_d = '0;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        word_cnt_d = word_cnt + RDMARD_WORD_W'(1);
        // Back-to-back header is safe: the next line lands after the
        // last word's select has been consumed.
        if (last_word) state_d = can_start ? ST_HDR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      ctag_q   <= '0;
      cur_ctag <= '0;
    end else begin
      state    <= state_d;
      word_cnt <= word_cnt_d;
      if (in_hdr) begin
        ctag_q   <= io_read_ctag(fifo_head);
        cur_ctag <= fifo_head;
      end
    end
  end

  assign sctag_scbuf_ctag_en_c7  = in_hdr;
  assign sctag_scbuf_req_en_c7   = in_hdr;
  assign sctag_scbuf_ctag_c7     = in_hdr ? io_read_ctag(fifo_head) : ctag_q;
  assign sctag_scbuf_word_vld_c7 = in_data;
  assign sctag_scbuf_word_c7     = in_data ? word_cnt : '0;

  // Delay line aligns each issued word with its returning error flags.
  always_ff @(posedge rclk) begin
    if (rst) begin
      dl_vld  <= '0;
      dl_last <= '0;
      for (int i = 0; i < ERR_LAT; i++) dl_ctag[i] <= '0;
    end else begin
      for (int i = ERR_LAT - 1; i > 0; i--) begin
        dl_vld[i]  <= dl_vld[i-1];
        dl_last[i] <= dl_last[i-1];
        dl_ctag[i] <= dl_ctag[i-1];
      end
      dl_vld[0]  <= in_data;
      dl_last[0] <= last_word;
      dl_ctag[0] <= cur_ctag;
    end
  end

  assign out_vld  = dl_vld[ERR_LAT-1];
  assign out_done = out_vld & dl_last[ERR_LAT-1];
  assign ue_any   = acc_ue | scbuf_sctag_rdma_uerr_c10;

  always_ff @(posedge rclk) begin
    if (rst || out_done) begin
      acc_ue <= 1'b0;
      acc_ce <= 1'b0;
    end else if (out_vld) begin
      acc_ue <= acc_ue | scbuf_sctag_rdma_uerr_c10;
      acc_ce <= acc_ce | scbuf_sctag_rdma_cerr_c10;
    end
  end

  assign rdmard_done      = out_done;
  assign rdmard_done_ctag = out_done ? dl_ctag[ERR_LAT-1] : '0;
  assign rdmard_done_ue   = out_done & ue_any;
  assign rdmard_done_ce   = out_done & (acc_ce | scbuf_sctag_rdma_cerr_c10) & ~ue_any;

  assign busy = ~fifo_empty | (state != ST_IDLE) | (|dl_vld);

endmodule
